// File: rtl/mm_result_writer_if.sv
// Result handshake and RAM write bus for the matrix-multiply
// write-back scheduler.
interface mm_result_writer_if #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 5
);
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              res_ready;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;

  modport slave (
    input  res_valid,
    input  res_data,
    output res_ready,
    output ram_en,
    output ram_we,
    output ram_addr,
    output ram_wdata
  );

  modport master (
    output res_valid,
    output res_data,
    input  res_ready,
    input  ram_en,
    input  ram_we,
    input  ram_addr,
    input  ram_wdata
  );
endinterface

// File: rtl/mm_result_writer.sv
// Write-back scheduler: 2-deep result FIFO drained into the result
// RAM at consecutive addresses, WR_CYC strobe cycles per word.
module mm_result_writer #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 5,
  parameter int N_RES  = 16,
  parameter int WR_CYC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start_in,
  mm_result_writer_if.slave bus,
  output logic ram_done,
  output logic busy,
  output logic err_ovf
);

  localparam int CW = (WR_CYC > 1) ? $clog2(WR_CYC) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(WR_CYC - 1);
  localparam logic [ADDR_W:0] N_LAST = (ADDR_W + 1)'(N_RES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic [1:0]        cnt_q, cnt_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [ADDR_W:0]   acc_q, acc_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d;
  logic [ADDR_W:0]   wnext;
  logic [CW-1:0]     cyc_q, cyc_d;
  logic              en_q, en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;
  logic              push;
  logic              pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      cnt_q    <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      acc_q    <= '0;
      wcnt_q   <= '0;
      cyc_q    <= '0;
      en_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_q    <= mem_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      acc_q    <= acc_d;
      wcnt_q   <= wcnt_d;
      cyc_q    <= cyc_d;
      en_q     <= en_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    acc_d   = acc_q;
    wcnt_d  = wcnt_q;
    cyc_d   = cyc_q;
    en_d    = en_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_d   = err_q;
    push    = bus.res_valid & ready_q;
    pop     = (state_q == S_WRITE) && (cyc_q == CYC_LAST);
    wnext   = wcnt_q + 1'b1;

    if (push) begin
      mem_d[wr_q] = bus.res_data;
      wr_d        = ~wr_q;
      acc_d       = acc_q + 1'b1;
    end
    if (pop) begin
      rd_d = ~rd_q;
    end
    cnt_d = cnt_q + 2'(push) - 2'(pop);

    if (bus.res_valid && !ready_q && busy_q) begin
      err_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start_in) begin
          state_d = S_WAIT;
          cnt_d   = '0;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          acc_d   = '0;
          wcnt_d  = '0;
          cyc_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_WAIT: begin
        // An empty FIFO forwards the incoming word so the strobe
        // starts the cycle right after acceptance.
        if (cnt_q != 2'd0 || push) begin
          state_d = S_WRITE;
          en_d    = 1'b1;
          cyc_d   = '0;
          addr_d  = wcnt_q[ADDR_W-1:0];
          wdata_d = (cnt_q != 2'd0) ? mem_q[rd_q] : bus.res_data;
        end
      end
      S_WRITE: begin
        if (!pop) begin
          cyc_d = cyc_q + 1'b1;
        end else begin
          wcnt_d = wnext;
          cyc_d  = '0;
          if (wnext == N_LAST) begin
            state_d = S_DONE;
            en_d    = 1'b0;
            done_d  = 1'b1;
          end else if (cnt_q == 2'd2 || push) begin
            addr_d  = wnext[ADDR_W-1:0];
            wdata_d = (cnt_q == 2'd2) ? mem_q[~rd_q] : bus.res_data;
          end else begin
            state_d = S_WAIT;
            en_d    = 1'b0;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        en_d    = 1'b0;
      end
    endcase

    busy_d  = (state_d != S_IDLE);
    ready_d = busy_d && (cnt_d != 2'd2) && (acc_d != N_LAST);
  end

  assign bus.res_ready = ready_q;
  assign bus.ram_en    = en_q;
  assign bus.ram_we    = en_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
  assign ram_done      = done_q;
  assign busy          = busy_q;
  assign err_ovf       = err_q;

endmodule

// File: tb/tb_mm_result_writer.sv
// Scoreboard bench: two instances (N_RES=4/WR_CYC=2 and
// N_RES=2/WR_CYC=3) checked by a RAM-bus monitor.
module tb_mm_result_writer;

  typedef struct {
    logic [4:0]  addr;
    logic [17:0] data;
    logic        contig;
    int          len;
  } wr_t;

  logic clk;
  logic rst;
  logic start0, start1;
  logic done0, done1;
  logic busy0, busy1;
  logic ovf0, ovf1;

  int n_chk;
  int n_pass;

  wr_t  q_w0[$];
  wr_t  q_w1[$];
  logic q_d0[$];
  logic q_d1[$];

  logic        in_b   [2];
  int          blen   [2];
  logic        stab   [2];
  logic        p_en   [2];
  logic [4:0]  p_addr [2];
  logic [4:0]  b_addr [2];
  logic [17:0] b_data [2];
  wr_t         cur    [2];

  mm_result_writer_if #(.DATA_W(18), .ADDR_W(5)) bus0 ();
  mm_result_writer_if #(.DATA_W(18), .ADDR_W(5)) bus1 ();

  mm_result_writer #(
    .DATA_W(18), .ADDR_W(5), .N_RES(4), .WR_CYC(2)
  ) u_dut0 (
    .clk      (clk),
    .rst      (rst),
    .start_in (start0),
    .bus      (bus0),
    .ram_done (done0),
    .busy     (busy0),
    .err_ovf  (ovf0)
  );

  mm_result_writer #(
    .DATA_W(18), .ADDR_W(5), .N_RES(2), .WR_CYC(3)
  ) u_dut1 (
    .clk      (clk),
    .rst      (rst),
    .start_in (start1),
    .bus      (bus1),
    .ram_done (done1),
    .busy     (busy1),
    .err_ovf  (ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expw(input int d, input int a, input int v,
                      input bit c, input int l);
    wr_t e;
    e.addr   = 5'(a);
    e.data   = 18'(v);
    e.contig = c;
    e.len    = l;
    if (d == 0) q_w0.push_back(e);
    else q_w1.push_back(e);
  endtask

  task automatic mon(input int d, input int wrc, input int nres,
                     input logic en, input logic we,
                     input logic [4:0] addr, input logic [17:0] data,
                     input logic done, input logic ovf);
    wr_t  e;
    logic sb;
    logic have;
    logic eerr;
    if (en || we) chk($sformatf("u%0d_we_eq_en", d), 32'(we), 32'(en));
    sb = en && (!in_b[d] || blen[d] == wrc);
    if (in_b[d] && (!en || blen[d] == wrc)) begin
      chk($sformatf("u%0d_burst_len", d), 32'(blen[d]), 32'(cur[d].len));
      chk($sformatf("u%0d_burst_stable", d), 32'(stab[d]), 32'd1);
      in_b[d] = 1'b0;
    end
    if (sb) begin
      have = (d == 0) ? (q_w0.size() > 0) : (q_w1.size() > 0);
      chk($sformatf("u%0d_burst_expected", d), 32'(have), 32'd1);
      e = '{addr: 5'd0, data: 18'd0, contig: 1'b0, len: 0};
      if (have) begin
        if (d == 0) e = q_w0.pop_front();
        else e = q_w1.pop_front();
      end
      chk($sformatf("u%0d_addr", d), 32'(addr), 32'(e.addr));
      chk($sformatf("u%0d_data", d), 32'(data), 32'(e.data));
      chk($sformatf("u%0d_gapless", d), 32'(p_en[d]), 32'(e.contig));
      cur[d]    = e;
      in_b[d]   = 1'b1;
      blen[d]   = 1;
      stab[d]   = 1'b1;
      b_addr[d] = addr;
      b_data[d] = data;
    end else if (en) begin
      blen[d]++;
      if (addr !== b_addr[d] || data !== b_data[d]) stab[d] = 1'b0;
    end
    if (done) begin
      have = (d == 0) ? (q_d0.size() > 0) : (q_d1.size() > 0);
      chk($sformatf("u%0d_done_expected", d), 32'(have), 32'd1);
      eerr = 1'b0;
      if (have) begin
        if (d == 0) eerr = q_d0.pop_front();
        else eerr = q_d1.pop_front();
      end
      chk($sformatf("u%0d_done_timing", d),
          32'({p_en[d], en}), 32'b10);
      chk($sformatf("u%0d_done_addr", d), 32'(p_addr[d]), 32'(nres - 1));
      chk($sformatf("u%0d_done_err", d), 32'(ovf), 32'(eerr));
    end
    p_en[d]   = en;
    p_addr[d] = addr;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      in_b[i] = 1'b0;
      blen[i] = 0;
      stab[i] = 1'b1;
      p_en[i] = 1'b0;
      p_addr[i] = '0;
    end
  end

  always @(negedge clk) begin
    mon(0, 2, 4, bus0.ram_en, bus0.ram_we, bus0.ram_addr,
        bus0.ram_wdata, done0, ovf0);
    mon(1, 3, 2, bus1.ram_en, bus1.ram_we, bus1.ram_addr,
        bus1.ram_wdata, done1, ovf1);
  end

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    bus0.res_valid = 1'b0;
    bus0.res_data  = '0;
    bus1.res_valid = 1'b0;
    bus1.res_data  = '0;

    // reset with random inputs
    for (int i = 0; i < 5; i++) begin
      start0 = 1'($urandom);
      start1 = 1'($urandom);
      bus0.res_valid = 1'($urandom);
      bus1.res_valid = 1'($urandom);
      bus0.res_data  = 18'($urandom);
      bus1.res_data  = 18'($urandom);
      step(1);
    end
    chk("rst_out0", 32'({bus0.res_ready, bus0.ram_en, bus0.ram_we,
        bus0.ram_addr, bus0.ram_wdata, done0, busy0, ovf0}), 32'd0);
    chk("rst_out1", 32'({bus1.res_ready, bus1.ram_en, bus1.ram_we,
        bus1.ram_addr, bus1.ram_wdata, done1, busy1, ovf1}), 32'd0);
    rst = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    bus0.res_valid = 1'b0;
    bus1.res_valid = 1'b0;
    step(1);

    // results in IDLE are ignored
    for (int i = 0; i < 3; i++) begin
      bus0.res_valid = 1'b1;
      bus0.res_data  = 18'h3ff;
      chk("idle_ready", 32'(bus0.res_ready), 32'd0);
      step(1);
    end
    bus0.res_valid = 1'b0;
    step(2);
    chk("idle_err", 32'(ovf0), 32'd0);
    chk("idle_busy", 32'(busy0), 32'd0);

    // sparse job
    expw(0, 0, 'h11, 0, 2);
    expw(0, 1, 'h22, 0, 2);
    expw(0, 2, 'h33, 0, 2);
    expw(0, 3, 'h44, 0, 2);
    q_d0.push_back(1'b0);
    start0 = 1'b1;
    step(1);
    start0 = 1'b0;
    chk("busy_after_start", 32'(busy0), 32'd1);
    for (int k = 0; k < 4; k++) begin
      bus0.res_valid = 1'b1;
      bus0.res_data  = 18'((k + 1) * 'h11);
      step(1);
      bus0.res_valid = 1'b0;
      step(4);
    end
    step(8);
    chk("idle_after_done", 32'(busy0), 32'd0);

    // back-to-back
    expw(0, 0, 'h1a5, 0, 2);
    expw(0, 1, 'h2b6, 1, 2);
    expw(0, 2, 'h3c7, 0, 2);
    expw(0, 3, 'h0d8, 0, 2);
    q_d0.push_back(1'b0);
    start0 = 1'b1;
    step(1);
    start0 = 1'b0;
    bus0.res_valid = 1'b1;
    bus0.res_data  = 18'h1a5;
    step(1);
    bus0.res_data  = 18'h2b6;
    chk("b2b_ready", 32'(bus0.res_ready), 32'd1);
    step(1);
    bus0.res_valid = 1'b0;
    step(6);
    bus0.res_valid = 1'b1;
    bus0.res_data  = 18'h3c7;
    step(1);
    bus0.res_valid = 1'b0;
    step(5);
    bus0.res_valid = 1'b1;
    bus0.res_data  = 18'h0d8;
    step(1);
    bus0.res_valid = 1'b0;
    step(8);

    // overflow: 4 consecutive results, WR_CYC=3
    expw(1, 0, 'h101, 0, 3);
    expw(1, 1, 'h202, 1, 3);
    q_d1.push_back(1'b1);
    start1 = 1'b1;
    step(1);
    start1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus1.res_valid = 1'b1;
      bus1.res_data  = 18'((k + 1) * 'h101);
      chk($sformatf("ovf_ready%0d", k), 32'(bus1.res_ready),
          32'(k < 2));
      step(1);
    end
    bus1.res_valid = 1'b0;
    step(10);
    chk("err_sticky", 32'(ovf1), 32'd1);
    start1 = 1'b1;
    step(1);
    start1 = 1'b0;
    chk("err_clear", 32'(ovf1), 32'd0);

    // excess result beyond N_RES
    expw(1, 0, 'h0aa, 0, 3);
    expw(1, 1, 'h0bb, 0, 3);
    q_d1.push_back(1'b1);
    bus1.res_valid = 1'b1;
    bus1.res_data  = 18'h0aa;
    step(1);
    bus1.res_valid = 1'b0;
    step(5);
    bus1.res_valid = 1'b1;
    bus1.res_data  = 18'h0bb;
    chk("exc_ready_last", 32'(bus1.res_ready), 32'd1);
    step(1);
    bus1.res_data  = 18'h0cc;
    chk("exc_ready_extra", 32'(bus1.res_ready), 32'd0);
    step(1);
    bus1.res_valid = 1'b0;
    step(8);

    // reset during first strobe cycle of address 1
    expw(0, 0, 'h155, 0, 2);
    expw(0, 1, 'h266, 1, 1);
    start0 = 1'b1;
    step(1);
    start0 = 1'b0;
    bus0.res_valid = 1'b1;
    bus0.res_data  = 18'h155;
    step(1);
    bus0.res_data  = 18'h266;
    step(1);
    bus0.res_valid = 1'b0;
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rst_mid_en", 32'(bus0.ram_en), 32'd0);
    chk("rst_mid_busy", 32'(busy0), 32'd0);
    step(2);

    // restart begins at address 0
    expw(0, 0, 'h0e1, 0, 2);
    expw(0, 1, 'h0f2, 0, 2);
    expw(0, 2, 'h103, 0, 2);
    expw(0, 3, 'h114, 0, 2);
    q_d0.push_back(1'b0);
    start0 = 1'b1;
    step(1);
    start0 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus0.res_valid = 1'b1;
      bus0.res_data  = 18'('h0e1 + k * 'h11);
      step(1);
      bus0.res_valid = 1'b0;
      step(4);
    end
    step(10);

    chk("left_w0", 32'(q_w0.size()), 32'd0);
    chk("left_w1", 32'(q_w1.size()), 32'd0);
    chk("left_d0", 32'(q_d0.size()), 32'd0);
    chk("left_d1", 32'(q_d1.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
